// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial scan sequencer.
package seq_scan_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Host-side start/busy/done handshake and result bus of the scan sequencer.
interface seq_scan_ctrl_if
  import seq_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] first_hit_idx;
  logic             hit_any;

  modport master (
    output start, data_in,
    input  busy, done, hit_count, first_hit_idx, hit_any
  );

  modport slave (
    input  start, data_in,
    output busy, done, hit_count, first_hit_idx, hit_any
  );

endinterface

// File: rtl/seq_scan_ctrl.sv
// Serialises a captured word MSB first into the run detector and tallies
// its z hits (equal adjacent bit pairs), reporting via start/busy/done.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            reset,
  seq_scan_ctrl_if.slave  host,
  input  logic            z_in,
  output logic            w_out,
  output logic            det_reset
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] first_hit_idx;
  logic             hit_any;

  logic             load;
  logic             hit;
  logic [CNT_W-1:0] hit_j;
  logic             busy_c;
  logic             done_c;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, detector drive and hit qualification.
  always_comb begin
    state_d   = state_q;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    det_reset = 1'b0;
    w_out     = 1'b0;
    load      = 1'b0;
    hit       = 1'b0;
    hit_j     = '0;
    case (state_q)
      IDLE: begin
        det_reset = 1'b1;
        if (host.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
        w_out  = sreg[WIDTH-1];
        // z at idx 0 is stale and at idx 1 there is no pair yet, so only
        // idx >= 2 can report pair j = idx-1.
        hit    = z_in && (idx > CNT_W'(1));
        hit_j  = idx - 1'b1;
        if (idx == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        busy_c  = 1'b1;
        hit     = z_in;
        hit_j   = LAST;
        state_d = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        det_reset = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit index and hit accumulator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg          <= '0;
      idx           <= '0;
      hit_count     <= '0;
      first_hit_idx <= '0;
      hit_any       <= 1'b0;
    end else if (load) begin
      sreg          <= host.data_in;
      idx           <= '0;
      hit_count     <= '0;
      first_hit_idx <= '0;
      hit_any       <= 1'b0;
    end else begin
      if (state_q == SHIFT) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
        idx  <= idx + 1'b1;
      end
      if (hit) begin
        hit_count <= hit_count + 1'b1;
        hit_any   <= 1'b1;
        if (hit_count == '0) first_hit_idx <= hit_j;
      end
    end
  end

  assign host.busy          = busy_c;
  assign host.done          = done_c;
  assign host.hit_count     = hit_count;
  assign host.first_hit_idx = first_hit_idx;
  assign host.hit_any       = hit_any;

endmodule
